// File: rtl/bus_arbiter_if.sv
// Bus bundle for bus_arbiter: two requester ports (M0 = CPU, M1 = DMA/debug)
// plus the single registered slave-side W_* bus.
// The master modport is the arbiter's view; slave is the view of the
// requesters and the memory/peripheral decoder that sit around it.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              M0_REQ;
    logic              M0_WE;
    logic [ADDR_W-1:0] M0_ADDR;
    logic [DATA_W-1:0] M0_DAT_O;
    logic [DATA_W-1:0] M0_DAT_I;
    logic              M0_ACK;
    logic              M0_ERR;

    logic              M1_REQ;
    logic              M1_WE;
    logic [ADDR_W-1:0] M1_ADDR;
    logic [DATA_W-1:0] M1_DAT_O;
    logic [DATA_W-1:0] M1_DAT_I;
    logic              M1_ACK;
    logic              M1_ERR;

    logic              W_STB;
    logic              W_WE;
    logic [ADDR_W-1:0] W_ADDR;
    logic [DATA_W-1:0] W_DAT_O;
    logic [DATA_W-1:0] W_DAT_I;
    logic              W_ACK;

    modport master (
        input  M0_REQ, M0_WE, M0_ADDR, M0_DAT_O,
        output M0_DAT_I, M0_ACK, M0_ERR,
        input  M1_REQ, M1_WE, M1_ADDR, M1_DAT_O,
        output M1_DAT_I, M1_ACK, M1_ERR,
        output W_STB, W_WE, W_ADDR, W_DAT_O,
        input  W_DAT_I, W_ACK
    );

    modport slave (
        output M0_REQ, M0_WE, M0_ADDR, M0_DAT_O,
        input  M0_DAT_I, M0_ACK, M0_ERR,
        output M1_REQ, M1_WE, M1_ADDR, M1_DAT_O,
        input  M1_DAT_I, M1_ACK, M1_ERR,
        input  W_STB, W_WE, W_ADDR, W_DAT_O,
        output W_DAT_I, W_ACK
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, single-slave round-robin arbiter for the W_* bus.
// One transaction at a time: IDLE (grant) -> BUSY (wait for W_ACK) ->
// RELEASE (one dead cycle so a finishing master can drop REQ) -> IDLE.
// Optional feature macro: ARB_TIMEOUT_EN -- aborts a BUSY phase after
// TIMEOUT cycles without W_ACK, answering the owner with Mx_ERR and a
// 32'hDEADBEEF data word. Without it, Mx_ERR is constant 0.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           W_RST,
    bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t state;
    // Master granted most recently; while BUSY this is the current owner.
    logic   last_grant;
    logic   pick_m1;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT != 0);
    assign bus.M0_ERR = 1'b0;
    assign bus.M1_ERR = 1'b0;
`endif

    // Round-robin pick: M1 wins alone, or on a tie when M0 was served last.
    always_comb begin
        pick_m1 = bus.M1_REQ && (!bus.M0_REQ || !last_grant);
    end

    // Arbitration FSM driving the registered slave bus and master responses.
    always_ff @(posedge clk) begin
        if (!W_RST) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            bus.W_STB    <= 1'b0;
            bus.W_WE     <= 1'b0;
            bus.W_ADDR   <= {ADDR_W{1'b0}};
            bus.W_DAT_O  <= {DATA_W{1'b0}};
            bus.M0_DAT_I <= {DATA_W{1'b0}};
            bus.M1_DAT_I <= {DATA_W{1'b0}};
            bus.M0_ACK   <= 1'b0;
            bus.M1_ACK   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.M0_ERR   <= 1'b0;
            bus.M1_ERR   <= 1'b0;
            tmo_cnt      <= 8'd0;
`endif
        end else begin
            // Responses are single-cycle pulses.
            bus.M0_ACK <= 1'b0;
            bus.M1_ACK <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.M0_ERR <= 1'b0;
            bus.M1_ERR <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.M0_REQ || bus.M1_REQ) begin
                        last_grant  <= pick_m1;
                        bus.W_STB   <= 1'b1;
                        bus.W_WE    <= pick_m1 ? bus.M1_WE    : bus.M0_WE;
                        bus.W_ADDR  <= pick_m1 ? bus.M1_ADDR  : bus.M0_ADDR;
                        bus.W_DAT_O <= pick_m1 ? bus.M1_DAT_O : bus.M0_DAT_O;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt     <= 8'd0;
`endif
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // W_ACK takes priority over a timeout hitting in the same cycle.
                    if (bus.W_ACK) begin
                        bus.W_STB <= 1'b0;
                        if (last_grant) begin
                            bus.M1_DAT_I <= bus.W_DAT_I;
                            bus.M1_ACK   <= 1'b1;
                        end else begin
                            bus.M0_DAT_I <= bus.W_DAT_I;
                            bus.M0_ACK   <= 1'b1;
                        end
                        state <= RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt == 8'(TIMEOUT)) begin
                        bus.W_STB <= 1'b0;
                        if (last_grant) begin
                            bus.M1_DAT_I <= DATA_W'(32'hDEADBEEF);
                            bus.M1_ERR   <= 1'b1;
                        end else begin
                            bus.M0_DAT_I <= DATA_W'(32'hDEADBEEF);
                            bus.M0_ERR   <= 1'b1;
                        end
                        state <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 4;

    logic clk = 1'b0;
    logic W_RST;
    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .W_RST (W_RST),
        .bus   (bus)
    );

    typedef struct {
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wd;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wd;
        int          waits;
        logic [31:0] rdata;
        int          win;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mdl [2];   // expected Mx_DAT_I contents

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ack(input int i);
        return (i == 1) ? bus.M1_ACK : bus.M0_ACK;
    endfunction

    function automatic logic get_err(input int i);
        return (i == 1) ? bus.M1_ERR : bus.M0_ERR;
    endfunction

    function automatic logic [31:0] get_dat(input int i);
        return (i == 1) ? bus.M1_DAT_I : bus.M0_DAT_I;
    endfunction

    task automatic set_master(input int i, input logic r, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
        if (i == 0) begin
            bus.M0_REQ = r; bus.M0_WE = we; bus.M0_ADDR = a; bus.M0_DAT_O = d;
        end else begin
            bus.M1_REQ = r; bus.M1_WE = we; bus.M1_ADDR = a; bus.M1_DAT_O = d;
        end
    endtask

    task automatic reset_dut();
        W_RST = 1'b0;
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.W_ACK = 1'b0;
        bus.W_DAT_I = 32'h0;
        step();
        step();
        W_RST = 1'b1;
        mdl[0] = 32'h0;
        mdl[1] = 32'h0;
    endtask

    // One full transaction from an IDLE arbiter, ending back in IDLE.
    task automatic do_txn(input vec_t v, input string tag);
        int w;
        logic [31:0] ea, ed;
        logic ewe;
        w   = v.win;
        ea  = (w == 1) ? v.m1_addr : v.m0_addr;
        ed  = (w == 1) ? v.m1_wd   : v.m0_wd;
        ewe = (w == 1) ? v.m1_we   : v.m0_we;
        set_master(0, v.m0_req, v.m0_we, v.m0_addr, v.m0_wd);
        set_master(1, v.m1_req, v.m1_we, v.m1_addr, v.m1_wd);
        step();
        chk({tag, ".stb"}, bus.W_STB, 1);
        chk({tag, ".addr"}, bus.W_ADDR, ea);
        chk({tag, ".we"}, bus.W_WE, ewe);
        chk({tag, ".wdat"}, bus.W_DAT_O, ed);
        for (int k = 0; k < v.waits; k++) begin
            step();
            chk({tag, ".stb_hold"}, bus.W_STB, 1);
            chk({tag, ".addr_hold"}, {bus.W_WE, bus.W_ADDR, bus.W_DAT_O}, {ewe, ea, ed});
            chk({tag, ".early_ack"}, {bus.M0_ACK, bus.M1_ACK}, 0);
        end
        bus.W_ACK = 1'b1;
        bus.W_DAT_I = v.rdata;
        step();
        bus.W_ACK = 1'b0;
        chk({tag, ".stb_drop"}, bus.W_STB, 0);
        chk({tag, ".win_ack"}, get_ack(w), 1);
        chk({tag, ".lose_ack"}, get_ack(1 - w), 0);
        chk({tag, ".err"}, {bus.M0_ERR, bus.M1_ERR}, 0);
        chk({tag, ".win_dat"}, get_dat(w), v.rdata);
        chk({tag, ".lose_dat"}, get_dat(1 - w), mdl[1 - w]);
        mdl[w] = v.rdata;
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk({tag, ".ack_pulse"}, {bus.M0_ACK, bus.M1_ACK}, 0);
        chk({tag, ".stb_rel"}, bus.W_STB, 0);
    endtask

    vec_t vecs [6];
    vec_t vx;

    // Random-run state: requester payloads and the transaction-level model.
    logic        rq  [2];
    logic        rwe [2];
    logic [31:0] rad [2];
    logic [31:0] rwd [2];
    logic        drop_pend [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int win;

        vecs[0] = '{1'b1, 1'b0, 32'h100,       32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        2, 32'hCAFEF00D, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h10,        32'h0,        1'b1, 1'b0, 32'h20,       32'h0,        0, 32'h11112222, 1};
        vecs[2] = '{1'b1, 1'b1, 32'h30,        32'hA5A5A5A5, 1'b1, 1'b0, 32'h40,       32'h0,        1, 32'h33334444, 0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h20000004, 32'h12345678, 3, 32'h0BADF00D, 1};
        vecs[4] = '{1'b0, 1'b0, 32'h0,         32'h0,        1'b1, 1'b0, 32'h50,       32'h0,        0, 32'h55556666, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h60,        32'h0,        1'b1, 1'b0, 32'h70,       32'h0,        0, 32'h77778888, 0};
        vx      = '{1'b1, 1'b0, 32'h800,       32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1, 32'h80808080, 0};

        // Reset values
        reset_dut();
        chk("rst.stb", bus.W_STB, 0);
        chk("rst.bus", {bus.W_WE, bus.W_ADDR, bus.W_DAT_O}, 0);
        chk("rst.dat", {bus.M0_DAT_I, bus.M1_DAT_I}, 0);
        chk("rst.ackerr", {bus.M0_ACK, bus.M1_ACK, bus.M0_ERR, bus.M1_ERR}, 0);

        // Directed vector table
        for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Spurious ACK while IDLE
        bus.W_ACK = 1'b1;
        bus.W_DAT_I = 32'hBAD0BAD0;
        step();
        bus.W_ACK = 1'b0;
        chk("spur_idle.ack", {bus.M0_ACK, bus.M1_ACK}, 0);
        chk("spur_idle.dat", {bus.M0_DAT_I, bus.M1_DAT_I}, {mdl[0], mdl[1]});
        chk("spur_idle.stb", bus.W_STB, 0);

        // REQ dropped mid-BUSY, then a spurious ACK during RELEASE
        set_master(0, 1'b1, 1'b1, 32'h500, 32'h55);
        step();
        set_master(0, 1'b0, 1'b1, 32'h500, 32'h55);
        step();
        step();
        chk("drop.stb", bus.W_STB, 1);
        chk("drop.addr", bus.W_ADDR, 32'h500);
        bus.W_ACK = 1'b1;
        bus.W_DAT_I = 32'h77;
        step();
        chk("drop.ack", bus.M0_ACK, 1);
        chk("drop.dat", bus.M0_DAT_I, 32'h77);
        mdl[0] = 32'h77;
        bus.W_DAT_I = 32'h88;
        step();
        bus.W_ACK = 1'b0;
        chk("spur_rel.ack", {bus.M0_ACK, bus.M1_ACK}, 0);
        chk("spur_rel.dat", {bus.M0_DAT_I, bus.M1_DAT_I}, {mdl[0], mdl[1]});
        step();

        // Reset in the middle of BUSY
        set_master(1, 1'b1, 1'b0, 32'h300, 32'h0);
        step();
        chk("rstbusy.grant", {bus.W_STB, bus.W_ADDR}, {1'b1, 32'h300});
        W_RST = 1'b0;
        step();
        W_RST = 1'b1;
        mdl[0] = 32'h0;
        mdl[1] = 32'h0;
        chk("rstbusy.stb", bus.W_STB, 0);
        chk("rstbusy.resp", {bus.M0_ACK, bus.M1_ACK, bus.M0_ERR, bus.M1_ERR}, 0);
        set_master(0, 1'b1, 1'b0, 32'h400, 32'h0);
        step();
        chk("rstbusy.next_m0", {bus.W_STB, bus.W_ADDR}, {1'b1, 32'h400});
        bus.W_ACK = 1'b1;
        bus.W_DAT_I = 32'h4444;
        step();
        bus.W_ACK = 1'b0;
        chk("rstbusy.ack", {bus.M0_ACK, bus.M1_ACK}, 2'b10);
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Fairness after reset with both requests held high
        reset_dut();
        set_master(0, 1'b1, 1'b0, 32'hA0, 32'h0);
        set_master(1, 1'b1, 1'b0, 32'hB0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!bus.W_STB && t < 10) begin
                step();
                t++;
            end
            chk("fair.grant_seen", bus.W_STB, 1);
            win = (bus.W_ADDR == 32'hB0) ? 1 : 0;
            chk($sformatf("fair.order%0d", k), win, k % 2);
            bus.W_ACK = 1'b1;
            bus.W_DAT_I = 32'hF000 + k;
            step();
            bus.W_ACK = 1'b0;
            chk($sformatf("fair.ack%0d", k), get_ack(k % 2), 1);
            chk($sformatf("fair.dat%0d", k), get_dat(k % 2), 32'hF000 + k);
            step();
        end
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_dut();

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: ERR after the TIMEOUT+1-th BUSY cycle
        set_master(0, 1'b1, 1'b0, 32'h700, 32'h0);
        step();
        t = 0;
        while (!bus.M0_ERR && t < 20) begin
            step();
            t++;
        end
        chk("tmo.cycles", t, TMO + 1);
        chk("tmo.stb", bus.W_STB, 0);
        chk("tmo.dat", bus.M0_DAT_I, 32'hDEADBEEF);
        chk("tmo.noack", {bus.M0_ACK, bus.M1_ACK, bus.M1_ERR}, 0);
        mdl[0] = 32'hDEADBEEF;
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("tmo.pulse", bus.M0_ERR, 0);
        do_txn(vx, "tmo.after");
        // W_ACK arriving on the timeout cycle wins
        set_master(0, 1'b1, 1'b0, 32'h900, 32'h0);
        step();
        repeat (TMO) step();
        bus.W_ACK = 1'b1;
        bus.W_DAT_I = 32'h90909090;
        step();
        bus.W_ACK = 1'b0;
        chk("tmo.tie_ack", bus.M0_ACK, 1);
        chk("tmo.tie_err", bus.M0_ERR, 0);
        chk("tmo.tie_dat", bus.M0_DAT_I, 32'h90909090);
        mdl[0] = 32'h90909090;
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
`else
        // Without the timeout feature BUSY waits indefinitely
        set_master(1, 1'b1, 1'b0, 32'h600, 32'h0);
        step();
        repeat (300) step();
        chk("notmo.stb", bus.W_STB, 1);
        chk("notmo.err", {bus.M0_ERR, bus.M1_ERR}, 0);
        bus.W_ACK = 1'b1;
        bus.W_DAT_I = 32'h60606060;
        step();
        bus.W_ACK = 1'b0;
        chk("notmo.ack", bus.M1_ACK, 1);
        mdl[1] = 32'h60606060;
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        do_txn(vx, "notmo.after");
`endif

        // Randomized run against a transaction-level model
        reset_dut();
        begin
            logic mlast;
            logic in_txn;
            logic g_ack;
            int   owner;
            int   free_at;
            int   wcnt;
            mlast = 1'b1;
            in_txn = 1'b0;
            owner = 0;
            free_at = 0;
            wcnt = 0;
            for (int i = 0; i < 2; i++) begin
                rq[i] = 1'b0; rwe[i] = 1'b0; rad[i] = 32'h0; rwd[i] = 32'h0; drop_pend[i] = 1'b0;
            end
            for (int e = 0; e < 800; e++) begin
                for (int i = 0; i < 2; i++) begin
                    if (drop_pend[i]) begin
                        rq[i] = 1'b0;
                        drop_pend[i] = 1'b0;
                    end else if (!rq[i] && $urandom_range(3, 0) == 0) begin
                        rq[i]  = 1'b1;
                        rwe[i] = 1'($urandom_range(1, 0));
                        rad[i] = $urandom;
                        rwd[i] = $urandom;
                    end
                    set_master(i, rq[i], rwe[i], rad[i], rwd[i]);
                end
                bus.W_DAT_I = $urandom;
                if (in_txn) begin
                    if (wcnt == 0) bus.W_ACK = 1'b1;
                    else begin
                        bus.W_ACK = 1'b0;
                        wcnt--;
                    end
                end else begin
                    bus.W_ACK = ($urandom_range(4, 0) == 0);
                end
                g_ack = 1'b0;
                if (in_txn && bus.W_ACK) begin
                    g_ack = 1'b1;
                    mdl[owner] = bus.W_DAT_I;
                    in_txn = 1'b0;
                    free_at = e + 2;
                    drop_pend[owner] = 1'b1;
                end else if (!in_txn && e >= free_at && (rq[0] || rq[1])) begin
                    owner = (rq[0] && rq[1]) ? (mlast ? 0 : 1) : (rq[1] ? 1 : 0);
                    mlast = (owner == 1);
                    in_txn = 1'b1;
                    wcnt = $urandom_range(3, 0);
                end
                step();
                chk("rnd.stb", bus.W_STB, in_txn);
                if (in_txn)
                    chk("rnd.bus", {bus.W_WE, bus.W_ADDR, bus.W_DAT_O}, {rwe[owner], rad[owner], rwd[owner]});
                chk("rnd.ack", {bus.M0_ACK, bus.M1_ACK},
                    {g_ack && owner == 0, g_ack && owner == 1});
                chk("rnd.err", {bus.M0_ERR, bus.M1_ERR}, 0);
                chk("rnd.dat", {bus.M0_DAT_I, bus.M1_DAT_I}, {mdl[0], mdl[1]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, single-slave arbiter for the CPU's W_* memory bus.
- Master 0 is the CPU; master 1 is a secondary requester (DMA or debug loader).
- Grants one master at a time using round-robin, drives one registered bus transaction, then routes the ACK and read data back to the winner.
- Sits between the masters and the memory/peripheral decoder.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles to wait for W_ACK before aborting. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- W_RST  in  1  reset, synchronous, active-low.
- M0_REQ  in  1  master 0 request; held high until M0_ACK or M0_ERR.
- M0_WE  in  1  master 0 write enable (1 = write).
- M0_ADDR  in  ADDR_W  master 0 address.
- M0_DAT_O  in  DATA_W  master 0 write data.
- M0_DAT_I  out  DATA_W  read data returned to master 0.
- M0_ACK  out  1  one-cycle completion pulse to master 0.
- M0_ERR  out  1  one-cycle timeout pulse to master 0.
- M1_REQ, M1_WE, M1_ADDR, M1_DAT_O, M1_DAT_I, M1_ACK, M1_ERR: same as the M0 set, for master 1.
- W_STB  out  1  slave strobe; high for the whole transaction.
- W_WE  out  1  slave write enable.
- W_ADDR  out  ADDR_W  slave address.
- W_DAT_O  out  DATA_W  slave write data.
- W_DAT_I  in  DATA_W  slave read data.
- W_ACK  in  1  slave acknowledge; one cycle, with valid W_DAT_I.

Behaviour:
- Reset (W_RST low at an edge) clears these to 0: W_STB, W_WE, W_ADDR, W_DAT_O, Mx_DAT_I, Mx_ACK, Mx_ERR, timeout counter.
- Reset sets state = IDLE and last_grant = 1, so master 0 wins the first tie.
- All outputs are registered.
- IDLE:
  - If exactly one REQ is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - On grant: latch its WE/ADDR/DAT_O into W_WE/W_ADDR/W_DAT_O, set W_STB = 1, set last_grant = winner, go to BUSY.
  - Latency: REQ sampled at edge N gives W_STB high after edge N.
- BUSY:
  - W_STB stays high; address, data and WE stay stable.
  - When W_ACK is sampled high:
    - W_STB goes low.
    - The winner's Mx_DAT_I is loaded with W_DAT_I; the loser's Mx_DAT_I keeps its value.
    - The winner's Mx_ACK pulses high for exactly one cycle.
    - Go to RELEASE.
  - W_ACK to Mx_ACK latency: 1 cycle. For writes, Mx_DAT_I is also updated (don't-care to the master).
- RELEASE:
  - Lasts one cycle; all requests are ignored; then go to IDLE.
  - This gives the master one cycle to drop REQ, so a stale REQ is never re-granted.
  - Minimum cost: 3 cycles per transaction at zero slave wait states.
- W_ACK sampled in IDLE or RELEASE is ignored: no Mx_ACK, no data update.
- A REQ that drops mid-BUSY does not abort the transaction; the cycle completes normally.
- Reset mid-BUSY: W_STB goes low at that edge and no ACK or ERR is issued.
- Fairness: with both REQs permanently high, grants alternate 0,1,0,1…
- Mx_ACK and Mx_ERR are never high together, and never high for both masters in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter, cleared on entry to BUSY, increments every BUSY cycle without W_ACK.
  - When the count equals TIMEOUT, W_STB drops, the winner's Mx_ERR pulses for one cycle, Mx_DAT_I is loaded with 32'hDEADBEEF, and the block goes to RELEASE.
  - W_ACK and the timeout in the same cycle: W_ACK wins, and the block responds with ACK, not ERR.
- When not defined:
  - No counter is built; Mx_ERR is tied to 0; BUSY waits for W_ACK indefinitely.

Test Plan:
- Single read: M0_REQ=1, M0_ADDR=32'h100, M0_WE=0; slave gives W_ACK after 2 cycles with W_DAT_I=32'hCAFEF00D → W_STB high with W_ADDR=32'h100; M0_ACK pulses once; M0_DAT_I=32'hCAFEF00D; M1 outputs unchanged.
- Simultaneous requests after reset: M0 and M1 both request, zero-wait slave → M0 is granted first, then M1; grant order 0,1,0,1 over 4 transactions.
- Write from M1: M1_WE=1, M1_ADDR=32'h2000_0004, M1_DAT_O=32'h12345678 → W_WE=1 with those values held for the whole of BUSY; M1_ACK pulses once.
- Spurious ACK: W_ACK pulsed while in IDLE → no Mx_ACK; Mx_DAT_I unchanged.
- Reset mid-transaction: W_RST low during BUSY → W_STB=0 next cycle; no ACK or ERR; next grant goes to M0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): slave never acks → M0_ERR pulses in the 5th BUSY cycle; M0_DAT_I=32'hDEADBEEF; the next request is serviced normally.
